// File: rtl/sel_scan_seq.sv
// Channel-select sequencer: steps through the enabled channels of a latched mask in
// ascending order, holding each for dwell+1 cycles, for one sweep or continuously.
module sel_scan_seq #(
    parameter int SEL_W   = 4,
    parameter int DWELL_W = 8
) (
    input  logic                  clk1,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  continuous,
    input  logic [2**SEL_W-1:0]   chan_mask,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [SEL_W-1:0]      select,
    output logic                  sel_valid,
    output logic                  step_pulse,
    output logic                  sweep_done,
    output logic                  busy,
    output logic                  dbg_state
);

    localparam int NCH = 2**SEL_W;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DWELL = 1'b1
    } state_t;

    // Returns {found, index}: lowest set bit of m, optionally restricted to bits above 'above'.
    function automatic logic [SEL_W:0] find_set(input logic [NCH-1:0] m,
                                                input logic [SEL_W-1:0] above,
                                                input logic strict);
        logic [SEL_W:0] res;
        res = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i] && (!strict || (i > int'(above)))) begin
                res = {1'b1, SEL_W'(i)};
            end
        end
        return res;
    endfunction

    state_t               r_state, w_state_nx;
    logic [NCH-1:0]       r_mask, w_mask_nx;
    logic [DWELL_W-1:0]   r_dwell, w_dwell_nx;
    logic                 r_cont, w_cont_nx;
    logic [DWELL_W-1:0]   r_cnt, w_cnt_nx;
    logic [SEL_W-1:0]     r_sel, w_sel_nx;
    logic                 r_valid, w_valid_nx;
    logic                 r_step, w_step_nx;
    logic                 r_done, w_done_nx;
    logic                 r_busy, w_busy_nx;

    logic [SEL_W:0]       w_in_low;
    logic [SEL_W:0]       w_lat_low;
    logic [SEL_W:0]       w_lat_next;

    assign w_in_low   = find_set(chan_mask, '0, 1'b0);
    assign w_lat_low  = find_set(r_mask, '0, 1'b0);
    assign w_lat_next = find_set(r_mask, r_sel, 1'b1);

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
            r_dwell <= '0;
            r_cont  <= 1'b0;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_step  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_mask  <= w_mask_nx;
            r_dwell <= w_dwell_nx;
            r_cont  <= w_cont_nx;
            r_cnt   <= w_cnt_nx;
            r_sel   <= w_sel_nx;
            r_valid <= w_valid_nx;
            r_step  <= w_step_nx;
            r_done  <= w_done_nx;
            r_busy  <= w_busy_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_mask_nx  = r_mask;
        w_dwell_nx = r_dwell;
        w_cont_nx  = r_cont;
        w_cnt_nx   = r_cnt;
        w_sel_nx   = r_sel;
        w_valid_nx = r_valid;
        w_busy_nx  = r_busy;
        w_step_nx  = 1'b0;
        w_done_nx  = 1'b0;

        case (r_state)
            S_IDLE: begin
                // An empty mask never starts a scan; stop overrides a coincident start.
                if (start && !stop && w_in_low[SEL_W]) begin
                    w_mask_nx  = chan_mask;
                    w_dwell_nx = dwell;
                    w_cont_nx  = continuous;
                    w_state_nx = S_DWELL;
                    w_sel_nx   = w_in_low[SEL_W-1:0];
                    w_valid_nx = 1'b1;
                    w_busy_nx  = 1'b1;
                    w_step_nx  = 1'b1;
                    w_cnt_nx   = '0;
                end
            end
            S_DWELL: begin
                if (stop) begin
                    w_state_nx = S_IDLE;
                    w_valid_nx = 1'b0;
                    w_busy_nx  = 1'b0;
                end else if (r_cnt == r_dwell) begin
                    w_cnt_nx = '0;
                    if (w_lat_next[SEL_W]) begin
                        w_sel_nx  = w_lat_next[SEL_W-1:0];
                        w_step_nx = 1'b1;
                    end else begin
                        w_done_nx = 1'b1;
                        if (r_cont && w_lat_low[SEL_W]) begin
                            w_sel_nx  = w_lat_low[SEL_W-1:0];
                            w_step_nx = 1'b1;
                        end else begin
                            // select deliberately keeps the last channel after a single sweep
                            w_state_nx = S_IDLE;
                            w_valid_nx = 1'b0;
                            w_busy_nx  = 1'b0;
                        end
                    end
                end else begin
                    w_cnt_nx = r_cnt + DWELL_W'(1);
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign select     = r_sel;
    assign sel_valid  = r_valid;
    assign step_pulse = r_step;
    assign sweep_done = r_done;
    assign busy       = r_busy;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_sel_scan_seq.sv
// Bench for sel_scan_seq: channel-list reference model compared every cycle, plus
// directed sequences with hand-derived select traces and pulse counts.
module tb_sel_scan_seq;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        continuous;
    logic [15:0] chan_mask;
    logic [7:0]  dwell;
    logic [3:0]  select;
    logic        sel_valid;
    logic        step_pulse;
    logic        sweep_done;
    logic        busy;
    logic        dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    sel_scan_seq #(.SEL_W(4), .DWELL_W(8)) dut (
        .clk1       (clk1),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .chan_mask  (chan_mask),
        .dwell      (dwell),
        .select     (select),
        .sel_valid  (sel_valid),
        .step_pulse (step_pulse),
        .sweep_done (sweep_done),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // clock / watchdog
    always #5 clk1 = ~clk1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // reference model: scan walks a list of enabled channel numbers
    logic [8:0] exp_q[$];
    bit         m_busy = 1'b0;
    int         m_list[$];
    int         m_pos = 0;
    int         m_t = 0;
    int         m_dw = 0;
    bit         m_cont = 1'b0;
    logic [3:0] m_sel = 4'd0;
    bit         m_step = 1'b0;
    bit         m_done = 1'b0;

    initial begin
        forever begin
            @(posedge clk1);
            m_step = 1'b0;
            m_done = 1'b0;
            if (rst) begin
                m_busy = 1'b0;
                m_sel  = 4'd0;
                m_list.delete();
            end else if (!m_busy) begin
                if (start && !stop && chan_mask != 16'h0) begin
                    m_list.delete();
                    for (int n = 0; n < 16; n++)
                        if (chan_mask[n]) m_list.push_back(n);
                    m_pos  = 0;
                    m_t    = 0;
                    m_dw   = int'(dwell);
                    m_cont = continuous;
                    m_sel  = 4'(m_list[0]);
                    m_busy = 1'b1;
                    m_step = 1'b1;
                end
            end else if (stop) begin
                m_busy = 1'b0;
            end else if (m_t == m_dw) begin
                m_t = 0;
                if (m_pos + 1 < m_list.size()) begin
                    m_pos  = m_pos + 1;
                    m_sel  = 4'(m_list[m_pos]);
                    m_step = 1'b1;
                end else begin
                    m_done = 1'b1;
                    if (m_cont) begin
                        m_pos  = 0;
                        m_sel  = 4'(m_list[0]);
                        m_step = 1'b1;
                    end else begin
                        m_busy = 1'b0;
                    end
                end
            end else begin
                m_t = m_t + 1;
            end
            exp_q.push_back({m_sel, m_busy, m_step, m_done, m_busy, m_busy});
        end
    end

    // scoreboard compare on the falling edge
    task automatic check_vec(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got sel=%0d valid=%b step=%b done=%b busy=%b st=%b, required sel=%0d valid=%b step=%b done=%b busy=%b st=%b",
                     name, $time, act[8:5], act[4], act[3], act[2], act[1], act[0],
                     exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk1);
            if (rst) begin
                check_vec("reset_hold", {select, sel_valid, step_pulse, sweep_done, busy, dbg_state}, 9'h000);
                exp_q.delete();
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_vec("model", {select, sel_valid, step_pulse, sweep_done, busy, dbg_state}, e);
            end
        end
    end

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk1);
        #2;
    endtask

    task automatic do_start(input logic [15:0] m, input logic [7:0] d, input logic c);
        chan_mask  = m;
        dwell      = d;
        continuous = c;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    int t_steps[$];
    int t_done;
    int t_done_sel;
    int t_done_busy;
    int t_done_valid;
    int t_busy_n;
    int held[16];

    task automatic clear_trace();
        t_steps.delete();
        t_done       = 0;
        t_done_sel   = -1;
        t_done_busy  = -1;
        t_done_valid = -1;
        t_busy_n     = 0;
        for (int k = 0; k < 16; k++) held[k] = 0;
    endtask

    task automatic trace(input int n);
        for (int k = 0; k < n; k++) begin
            if (step_pulse) t_steps.push_back(int'(select));
            if (sweep_done) begin
                t_done++;
                t_done_sel   = int'(select);
                t_done_busy  = int'(busy);
                t_done_valid = int'(sel_valid);
            end
            if (sel_valid) held[select]++;
            if (busy) t_busy_n++;
            tick();
        end
    endtask

    task automatic check_steps(input string name, input int e[$]);
        check_int({name, "_count"}, t_steps.size(), e.size());
        for (int k = 0; k < e.size(); k++)
            check_int({name, "_sel"}, (k < t_steps.size()) ? t_steps[k] : -1, e[k]);
    endtask

    // directed sequences, then randomized traffic
    initial begin
        int k;
        rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
        chan_mask = 16'h0; dwell = 8'h0;
        tick(); tick();
        rst = 1'b0;
        check_int("rst_select", int'(select), 0);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_valid", int'(sel_valid), 0);

        // single sweep 0x8421, dwell 2
        clear_trace();
        do_start(16'h8421, 8'd2, 1'b0);
        trace(14);
        check_steps("sweep_steps", '{0, 5, 10, 15});
        check_int("sweep_hold15", held[15], 3);
        check_int("sweep_hold5", held[5], 3);
        check_int("sweep_done_n", t_done, 1);
        check_int("sweep_done_sel", t_done_sel, 15);
        check_int("sweep_done_busy", t_done_busy, 0);
        check_int("sweep_done_valid", t_done_valid, 0);
        check_int("sweep_end_sel", int'(select), 15);

        // continuous, two channels, dwell 0, then stop
        clear_trace();
        do_start(16'h0003, 8'd0, 1'b1);
        trace(8);
        check_steps("cont_steps", '{0, 1, 0, 1, 0, 1, 0, 1});
        check_int("cont_done_n", t_done, 3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_int("cont_stop_busy", int'(busy), 0);
        check_int("cont_stop_done", int'(sweep_done), 0);
        check_int("cont_stop_step", int'(step_pulse), 0);

        // reset mid-scan at select 5
        do_start(16'hFFFF, 8'd2, 1'b1);
        k = 0;
        while (select != 4'd5 && k < 200) begin
            tick();
            k++;
        end
        check_int("reach_sel5", int'(select == 4'd5), 1);
        rst = 1'b1;
        #1;
        check_int("midrst_select", int'(select), 0);
        check_int("midrst_busy", int'(busy), 0);
        check_int("midrst_pulses", int'({step_pulse, sweep_done, sel_valid}), 0);
        tick();
        rst = 1'b0;
        clear_trace();
        trace(5);
        check_int("midrst_idle", t_busy_n, 0);
        check_int("midrst_nodone", t_done, 0);

        // empty mask, start+stop collision
        clear_trace();
        do_start(16'h0000, 8'd1, 1'b0);
        trace(3);
        check_int("empty_busy", t_busy_n, 0);
        chan_mask = 16'h000F; dwell = 8'd0; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        clear_trace();
        trace(3);
        check_int("collide_busy", t_busy_n, 0);

        // start while busy is ignored
        clear_trace();
        do_start(16'h0006, 8'd1, 1'b0);
        trace(1);
        chan_mask = 16'h0001; start = 1'b1;
        trace(1);
        start = 1'b0;
        trace(4);
        check_steps("busy_start_steps", '{1, 2});
        check_int("busy_start_done", t_done, 1);

        // input changes mid-scan have no effect until the next start
        clear_trace();
        do_start(16'h00F0, 8'd1, 1'b0);
        trace(1);
        chan_mask = 16'h0001; dwell = 8'd7;
        trace(9);
        check_steps("iso_steps", '{4, 5, 6, 7});
        check_int("iso_hold7", held[7], 2);
        check_int("iso_done", t_done, 1);
        clear_trace();
        do_start(16'h0001, 8'd7, 1'b0);
        trace(10);
        check_int("iso2_hold0", held[0], 8);
        check_int("iso2_done", t_done, 1);

        // single channel 15, dwell 4
        clear_trace();
        do_start(16'h8000, 8'd4, 1'b0);
        trace(7);
        check_int("single_hold15", held[15], 5);
        check_int("single_steps", t_steps.size(), 1);
        check_int("single_done", t_done, 1);
        check_int("single_busy", int'(busy), 0);

        // randomized traffic, checked by the model
        for (int it = 0; it < 40; it++) begin
            do_start(($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom & $urandom),
                     8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(5, 40)) begin
                case ($urandom_range(0, 19))
                    0: stop = 1'b1;
                    1: begin start = 1'b1; chan_mask = 16'($urandom); end
                    2: dwell = 8'($urandom_range(0, 5));
                    3: continuous = ~continuous;
                    default: ;
                endcase
                tick();
                start = 1'b0;
                stop  = 1'b0;
            end
            stop = 1'b1;
            tick();
            stop = 1'b0;
            tick();
        end

        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
